// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// RAM lane reordering and natural-alignment checking.
package lsu_pkg;

  typedef enum logic [1:0] {
    LEN_B = 2'b00,
    LEN_H = 2'b01,
    LEN_W = 2'b10,
    LEN_D = 2'b11
  } len_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  // The RAM writes in[63:56] to the lowest address, so byte k of the data goes to lane 7-k.
  function automatic logic [63:0] byte_rev64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[63-8*k -: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic misaligned(input logic [2:0] addr, input len_e len);
    logic m;
    case (len)
      LEN_B:   m = 1'b0;
      LEN_H:   m = addr[0];
      LEN_W:   m = |addr[1:0];
      default: m = |addr[2:0];
    endcase
    return m;
  endfunction

  function automatic logic [63:0] len_mask(input len_e len);
    logic [63:0] m;
    case (len)
      LEN_B:   m = 64'h0000_0000_0000_00ff;
      LEN_H:   m = 64'h0000_0000_0000_ffff;
      LEN_W:   m = 64'h0000_0000_ffff_ffff;
      default: m = 64'hffff_ffff_ffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request/response channels plus the RAM data port, as seen by the LSU.
interface lsu_if #(
  parameter int unsigned ALEN = 64,
  parameter int unsigned DLEN = 64
);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [ALEN-1:0] req_addr;
  logic [1:0]      req_len;
  logic            req_signed;
  logic [DLEN-1:0] req_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [DLEN-1:0] rsp_rdata;
  logic            rsp_err;

  logic [ALEN-1:0] mem_addr;
  logic [DLEN-1:0] mem_wdata;
  logic [1:0]      mem_len;
  logic            mem_we;
  logic            mem_re;
  logic [DLEN-1:0] mem_rdata;

  // LSU side
  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_signed, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_addr, mem_wdata, mem_len, mem_we, mem_re,
    input  mem_rdata
  );

  // Execute stage and RAM side
  modport master (
    output req_valid, req_we, req_addr, req_len, req_signed, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_addr, mem_wdata, mem_len, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_extend.sv
// Load data extraction: picks the low-order bytes of the RAM word for the access
// size and sign- or zero-extends them to the full data width.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int unsigned DLEN = 64
) (
  input  logic [DLEN-1:0] mem_rdata,
  input  len_e            len,
  input  logic            sgn,
  output logic [DLEN-1:0] rdata
);

  always_comb begin
    rdata = '0;
    case (len)
      LEN_B:   rdata = {{(DLEN-8){sgn & mem_rdata[7]}}, mem_rdata[7:0]};
      LEN_H:   rdata = {{(DLEN-16){sgn & mem_rdata[15]}}, mem_rdata[15:0]};
      LEN_W:   rdata = {{(DLEN-32){sgn & mem_rdata[31]}}, mem_rdata[31:0]};
      default: rdata = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding memory operation, three-state FSM with registered
// RAM strobes and a held response until the execute stage consumes it.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ALEN = 64,
  parameter int unsigned DLEN = 64
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  lsu_state_e      state_q, state_d;
  len_e            len_q, len_d;
  logic            we_q, we_d;
  logic            sgn_q, sgn_d;
  logic            err_q, err_d;
  logic [DLEN-1:0] rdata_q, rdata_d;
  logic [ALEN-1:0] mem_addr_q, mem_addr_d;
  logic [DLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_re_q, mem_re_d;
  logic [DLEN-1:0] ext_rdata;
  len_e            req_len;
  logic            req_mis;

  assign req_len = len_e'(bus.req_len);
  assign req_mis = misaligned(bus.req_addr[2:0], req_len);

  lsu_extend #(
    .DLEN(DLEN)
  ) u_extend (
    .mem_rdata(bus.mem_rdata),
    .len      (len_q),
    .sgn      (sgn_q),
    .rdata    (ext_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    we_d        = we_q;
    sgn_d       = sgn_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Strobes are pulses: they only survive the single cycle spent in ACCESS.
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          len_d      = req_len;
          we_d       = bus.req_we;
          sgn_d      = bus.req_signed;
          mem_addr_d = bus.req_addr;
          rdata_d    = '0;
          err_d      = req_mis;
          if (req_mis) begin
            state_d = RESP;
          end else begin
            state_d     = ACCESS;
            mem_we_d    = bus.req_we;
            mem_re_d    = ~bus.req_we;
            mem_wdata_d = bus.req_we ? byte_rev64(bus.req_wdata & len_mask(req_len)) : '0;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) begin
          rdata_d = ext_rdata;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= LEN_B;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      len_q       <= len_d;
      we_q        <= we_d;
      sgn_q       <= sgn_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_len   = len_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;

  a_strobe_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_we && bus.mem_re));

  a_strobe_in_access : assert property (@(posedge clk) disable iff (rst)
    (bus.mem_we || bus.mem_re) |-> (state_q == ACCESS));

  a_rsp_stable : assert property (@(posedge clk) disable iff (rst)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_rdata) && $stable(bus.rsp_err)));

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-addressed RAM model on the data port and a
// scoreboard of expected responses (data, error flag, latency).
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_if #(.ALEN(64), .DLEN(64)) bus ();

  lsu #(
    .ALEN(64),
    .DLEN(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM model: in[63:56] lands at the lowest address, out1[7:0] is the lowest address.
  logic [7:0]  ram [1024];
  logic [63:0] rd;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    end else if (bus.mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (i < (1 << bus.mem_len)) ram[10'(bus.mem_addr + 64'(i))] <= bus.mem_wdata[63-8*i -: 8];
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < 8; i++) rd[8*i +: 8] = ram[10'(bus.mem_addr + 64'(i))];
  end
  assign bus.mem_rdata = rd;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          hs;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: latency runs from the accepting edge to the first cycle of rsp_valid.
  initial begin
    bit   prev;
    int   first;
    exp_t e;
    prev  = 1'b0;
    first = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.rsp_valid && !prev) first = cyc;
        prev = bus.rsp_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
          end else begin
            e = sb_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            chk("rsp_latency", 64'(first - e.hs + 1), 64'(e.lat));
          end
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [63:0] addr, input logic [1:0] len,
                       input bit sgn, input logic [63:0] wdata, input logic [63:0] exp_wdata,
                       input logic [63:0] exp_rdata, input bit exp_err);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 64'(bus.req_ready), 64'(1));
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_len    = len;
    bus.req_signed = sgn;
    bus.req_wdata  = wdata;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err, lat: (exp_err ? 1 : 2), hs: cyc + 1});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    if (!exp_err) begin
      chk("access_we", 64'(bus.mem_we), 64'(we));
      chk("access_re", 64'(bus.mem_re), 64'(!we));
      chk("access_addr", bus.mem_addr, addr);
      chk("access_len", 64'(bus.mem_len), 64'(len));
      if (we) chk("access_wdata", bus.mem_wdata, exp_wdata);
    end else begin
      chk("err_no_strobe", 64'({bus.mem_we, bus.mem_re}), 64'(0));
    end
    @(negedge clk);
    chk("strobe_drop", 64'({bus.mem_we, bus.mem_re}), 64'(0));
  endtask

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("rst_mem_addr", bus.mem_addr, 64'(0));
    chk("rst_mem_wdata", bus.mem_wdata, 64'(0));
    chk("rst_mem_len_we_re", 64'({bus.mem_len, bus.mem_we, bus.mem_re}), 64'(0));
    @(negedge clk);
    rst     = 1'b0;
    ram_clr = 1'b0;

    // we, addr, len, signed, wdata, expected mem_wdata, expected rdata, expected err
    issue(1, 64'h100, 2'b11, 0, 64'h1122334455667788, 64'h8877665544332211, 64'h0, 0);
    issue(0, 64'h100, 2'b11, 1, 64'h0, 64'h0, 64'h1122334455667788, 0);
    issue(1, 64'h20, 2'b10, 0, 64'h12345678DEADBEEF, 64'hEFBEADDE00000000, 64'h0, 0);
    issue(0, 64'h20, 2'b10, 1, 64'h0, 64'h0, 64'hFFFFFFFFDEADBEEF, 0);
    issue(0, 64'h20, 2'b10, 0, 64'h0, 64'h0, 64'h00000000DEADBEEF, 0);
    issue(1, 64'h50, 2'b01, 0, 64'hFFFFFFFFFFFF7F80, 64'h807F000000000000, 64'h0, 0);
    issue(0, 64'h50, 2'b00, 1, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFF80, 0);
    issue(0, 64'h50, 2'b00, 0, 64'h0, 64'h0, 64'h0000000000000080, 0);
    issue(1, 64'h13, 2'b00, 0, 64'h55555555555555AB, 64'hAB00000000000000, 64'h0, 0);
    issue(0, 64'h12, 2'b01, 1, 64'h0, 64'h0, 64'hFFFFFFFFFFFFAB00, 0);
    issue(1, 64'h13, 2'b01, 0, 64'h1234, 64'h0, 64'h0, 1);
    issue(0, 64'h22, 2'b10, 0, 64'h0, 64'h0, 64'h0, 1);
    issue(0, 64'h104, 2'b11, 0, 64'h0, 64'h0, 64'h0, 1);
    issue(0, 64'h12, 2'b01, 0, 64'h0, 64'h0, 64'h000000000000AB00, 0);

    // Back-pressure: response held for 5 cycles while a stray request is presented.
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    issue(0, 64'h100, 2'b11, 0, 64'h0, 64'h0, 64'h1122334455667788, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 64'h0;
      bus.req_len   = 2'b11;
      bus.req_wdata = 64'hA5A5A5A5A5A5A5A5;
      @(negedge clk);
      chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("stall_rsp_rdata", bus.rsp_rdata, 64'h1122334455667788);
      chk("stall_req_ready", 64'(bus.req_ready), 64'(0));
      chk("stall_no_strobe", 64'({bus.mem_we, bus.mem_re}), 64'(0));
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_stall_no_strobe", 64'({bus.mem_we, bus.mem_re}), 64'(0));
    end
    chk("post_stall_idle", 64'({bus.req_ready, bus.rsp_valid}), 64'b10);

    // Reset during the ACCESS cycle of a store: strobe drops, no response follows.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 64'h40;
    bus.req_len   = 2'b10;
    bus.req_wdata = 64'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstacc_we_before", 64'(bus.mem_we), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstacc_we_after", 64'(bus.mem_we), 64'(0));
    chk("rstacc_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rstacc_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rstacc_no_rsp", 64'(bus.rsp_valid), 64'(0));
    end
    issue(0, 64'h20, 2'b10, 0, 64'h0, 64'h0, 64'h00000000DEADBEEF, 0);

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
